// File: rtl/ysyx_2022040010_isram_resp_pkg.sv
// Shared constants and types for the instruction-SRAM responder.
//   PC_MBASE        reset PC / byte address of instruction word 0
//   ISRAM_DEPTH     number of 64-bit words in the instruction image
//   ISRAM_LAT       default request-to-response latency (1..4)
//   ISRAM_NOP_INST  instruction returned on a faulting fetch (addi x0, x0, 0)
//   ISRAM_RESP_BUS  width of the packed response bus {valid, err, inst, pc}
package ysyx_2022040010_isram_resp_pkg;

  localparam logic [63:0] PC_MBASE       = 64'h0000_0000_8000_0000;
  localparam int unsigned ISRAM_DEPTH    = 4096;
  localparam int unsigned ISRAM_LAT      = 1;
  localparam logic [31:0] ISRAM_NOP_INST = 32'h0000_0013;
  localparam int unsigned ISRAM_RESP_BUS = 98;

  // Field order matches the ID-stage latch: {valid, err, inst[31:0], pc[63:0]}.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] inst;
    logic [63:0] pc;
  } isram_resp_t;

  function automatic logic [31:0] half_sel(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/ysyx_2022040010_isram_array.sv
// DEPTH x 64-bit instruction image.
//   clk, rst : clock, synchronous active-high reset (clears the read register only)
//   re, ridx : read enable / word index; data appears on rdata after the edge
//   rdata    : registered read data, holds its value when re=0
//   we, widx, wdata, wstrb : byte-masked write port; out-of-range widx is ignored
// A read and a write to the same word in one cycle returns the old contents.
module ysyx_2022040010_isram_array #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [63:0]              rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [63:0]              wdata,
  input  logic [7:0]               wstrb
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[ridx];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // Image contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && (32'(widx) < DEPTH)) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_2022040010_isram_resp.sv
// Instruction-SRAM responder on the slave side of the IF fetch interface.
//   clk, rst              : clock, synchronous active-high reset
//   isram_e, isram_addr   : fetch request (accepted every cycle, no backpressure)
//   flush                 : drop every in-flight response; same-cycle request survives
//   resp_valid/pc/inst/err: response LATENCY cycles after the request; payload holds
//                           its last value while resp_valid=0
//   load_we/idx/wdata/strb: byte-masked image preload port
//   fetch_cnt, err_cnt    : wrapping counters of accepted and faulting fetches
module ysyx_2022040010_isram_resp
  import ysyx_2022040010_isram_resp_pkg::*;
#(
  parameter logic [63:0] BASE     = PC_MBASE,
  parameter int unsigned DEPTH    = ISRAM_DEPTH,
  parameter int unsigned LATENCY  = ISRAM_LAT,  // legal range 1..4
  parameter logic [31:0] NOP_INST = ISRAM_NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     isram_e,
  input  logic [63:0]              isram_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  output logic [63:0]              resp_pc,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [63:0]              load_wdata,
  input  logic [7:0]               load_strb,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              err_cnt
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  // Request decode
  logic [63:0]     off;
  logic [IdxW-1:0] idx;
  logic            in_range, misaligned, fault, accept;
  logic            unused_off;

  always_comb begin
    off        = isram_addr - BASE;
    // Unsigned compare first so addresses below BASE never wrap into range.
    in_range   = (isram_addr >= BASE) && (off[63:3] < 61'(DEPTH));
    misaligned = |isram_addr[1:0];
    fault      = misaligned | ~in_range;
    idx        = off[IdxW+2:3];
    accept     = isram_e & ~rst;
  end

  assign unused_off = ^off[2:0];

  // First stage: array read register plus the request metadata beside it.
  logic        s0_valid_q, s0_valid_d;
  logic [63:0] s0_pc_q, s0_pc_d;
  logic        s0_err_q, s0_err_d;
  logic        s0_hi_q, s0_hi_d;
  logic [63:0] rdata;

  always_comb begin
    // Flush never kills the request presented in the same cycle.
    s0_valid_d = accept;
    s0_pc_d    = s0_pc_q;
    s0_err_d   = s0_err_q;
    s0_hi_d    = s0_hi_q;
    if (accept) begin
      s0_pc_d  = isram_addr;
      s0_err_d = fault;
      s0_hi_d  = isram_addr[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_pc_q    <= '0;
      s0_err_q   <= 1'b0;
      s0_hi_q    <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_pc_q    <= s0_pc_d;
      s0_err_q   <= s0_err_d;
      s0_hi_q    <= s0_hi_d;
    end
  end

  ysyx_2022040010_isram_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .re    (accept & ~fault),
    .ridx  (idx),
    .rdata (rdata),
    .we    (load_we),
    .widx  (load_idx),
    .wdata (load_wdata),
    .wstrb (load_strb)
  );

  isram_resp_t s0_resp, resp;

  always_comb begin
    s0_resp.valid = s0_valid_q;
    s0_resp.err   = s0_err_q;
    s0_resp.inst  = s0_err_q ? NOP_INST : half_sel(rdata, s0_hi_q);
    s0_resp.pc    = s0_pc_q;
  end

  // Extra delay stages. Payload only advances with a surviving valid so the
  // output payload stays put while resp_valid is low.
  if (LATENCY <= 1) begin : g_direct
    assign resp = s0_resp;
  end else begin : g_pipe
    localparam int unsigned NStage = LATENCY - 1;
    isram_resp_t pipe_q [NStage];
    isram_resp_t pipe_d [NStage];

    always_comb begin
      for (int i = 0; i < NStage; i++) pipe_d[i] = pipe_q[i];
      if (s0_resp.valid && !flush) pipe_d[0] = s0_resp;
      else                         pipe_d[0].valid = 1'b0;
      for (int i = 1; i < NStage; i++) begin
        if (pipe_q[i-1].valid && !flush) pipe_d[i] = pipe_q[i-1];
        else                             pipe_d[i].valid = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < NStage; i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < NStage; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign resp = pipe_q[NStage-1];
  end

  // Statistics; flushed requests are still counted.
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(accept);
    err_cnt_d   = err_cnt_q + 32'(accept & fault);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign resp_valid = resp.valid;
  assign resp_pc    = resp.pc;
  assign resp_inst  = resp.inst;
  assign resp_err   = resp.err;
  assign fetch_cnt  = fetch_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ysyx_2022040010_isram_resp.sv
// Bench for ysyx_2022040010_isram_resp: three instances (LATENCY 1, 3, 4) share
// one stimulus stream and are compared every cycle against a history-based model.
module tb_ysyx_2022040010_isram_resp;

  localparam logic [63:0] Base   = 64'h0000_0000_8000_0000;
  localparam int unsigned Depth  = 4096;
  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam int          MaxCyc = 8192;

  logic        clk = 1'b0;
  logic        rst, isram_e, flush, load_we;
  logic [63:0] isram_addr, load_wdata;
  logic [11:0] load_idx;
  logic [7:0]  load_strb;

  logic        rv    [3];
  logic [63:0] rpc   [3];
  logic [31:0] rinst [3];
  logic        rerr  [3];
  logic [31:0] fcnt  [3];
  logic [31:0] ecnt  [3];

  always #5 clk = ~clk;

  ysyx_2022040010_isram_resp #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .resp_valid(rv[0]), .resp_pc(rpc[0]), .resp_inst(rinst[0]), .resp_err(rerr[0]),
    .load_we(load_we), .load_idx(load_idx), .load_wdata(load_wdata), .load_strb(load_strb),
    .fetch_cnt(fcnt[0]), .err_cnt(ecnt[0])
  );
  ysyx_2022040010_isram_resp #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .resp_valid(rv[1]), .resp_pc(rpc[1]), .resp_inst(rinst[1]), .resp_err(rerr[1]),
    .load_we(load_we), .load_idx(load_idx), .load_wdata(load_wdata), .load_strb(load_strb),
    .fetch_cnt(fcnt[1]), .err_cnt(ecnt[1])
  );
  ysyx_2022040010_isram_resp #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .isram_e(isram_e), .isram_addr(isram_addr), .flush(flush),
    .resp_valid(rv[2]), .resp_pc(rpc[2]), .resp_inst(rinst[2]), .resp_err(rerr[2]),
    .load_we(load_we), .load_idx(load_idx), .load_wdata(load_wdata), .load_strb(load_strb),
    .fetch_cnt(fcnt[2]), .err_cnt(ecnt[2])
  );

  // Reference model state: image, per-cycle request history, counters.
  logic [63:0] mem    [Depth];
  bit          h_acc  [MaxCyc];
  bit          h_rst  [MaxCyc];
  bit          h_kill [MaxCyc];
  bit          h_err  [MaxCyc];
  logic [63:0] h_pc   [MaxCyc];
  logic [31:0] h_inst [MaxCyc];
  logic [63:0] last_pc   [3];
  logic [31:0] last_inst [3];
  logic        last_err  [3];
  logic [31:0] m_fcnt, m_ecnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;
  vec_t vecs [9];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_fetch(input logic [63:0] a, output logic [31:0] inst,
                                    output bit err);
    logic [63:0] off;
    logic [63:0] word;
    bit          in_r;
    off  = a - Base;
    in_r = (a >= Base) && ((off >> 3) < 64'(Depth));
    err  = (a[1:0] != 2'b00) || !in_r;
    word = mem[off[14:3]];
    inst = err ? Nop : (a[2] ? word[63:32] : word[31:0]);
  endfunction

  // Compare this cycle's outputs, then log this cycle's inputs into the model.
  task automatic model_cycle();
    int t;
    t = cyc;
    if (t >= MaxCyc) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", t, MaxCyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (t >= 2) begin
      for (int k = 0; k < 3; k++) begin
        int l;
        int s;
        bit ev;
        l  = lat_of(k);
        s  = t - l;
        ev = 1'b0;
        if (s >= 0) begin
          ev = h_acc[s];
          for (int f = s + 1; f < t; f++) if (h_kill[f]) ev = 1'b0;
        end
        if (h_rst[t-1]) begin
          last_pc[k]   = '0;
          last_inst[k] = '0;
          last_err[k]  = 1'b0;
        end else if (ev) begin
          last_pc[k]   = h_pc[s];
          last_inst[k] = h_inst[s];
          last_err[k]  = h_err[s];
        end
        chk($sformatf("lat%0d_valid@%0d", l, t), 64'(rv[k]), 64'(ev));
        chk($sformatf("lat%0d_pc@%0d", l, t), rpc[k], last_pc[k]);
        chk($sformatf("lat%0d_inst@%0d", l, t), 64'(rinst[k]), 64'(last_inst[k]));
        chk($sformatf("lat%0d_err@%0d", l, t), 64'(rerr[k]), 64'(last_err[k]));
        chk($sformatf("lat%0d_fetch_cnt@%0d", l, t), 64'(fcnt[k]), 64'(m_fcnt));
        chk($sformatf("lat%0d_err_cnt@%0d", l, t), 64'(ecnt[k]), 64'(m_ecnt));
      end
    end
    h_rst[t]  = rst;
    h_kill[t] = rst | flush;
    h_acc[t]  = isram_e & ~rst;
    h_pc[t]   = isram_addr;
    ref_fetch(isram_addr, h_inst[t], h_err[t]);
    if (load_we) begin
      for (int b = 0; b < 8; b++) begin
        if (load_strb[b]) mem[load_idx][8*b +: 8] = load_wdata[8*b +: 8];
      end
    end
    if (rst) begin
      m_fcnt = '0;
      m_ecnt = '0;
    end else if (h_acc[t]) begin
      m_fcnt = m_fcnt + 1;
      if (h_err[t]) m_ecnt = m_ecnt + 1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst     = 1'b0;
    isram_e = 1'b0;
    flush   = 1'b0;
    load_we = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned sel;
    logic [63:0] widx;
    sel  = $urandom_range(0, 9);
    widx = 64'($urandom_range(0, Depth - 1));
    if (sel <= 5)      return Base + (widx << 3) + ($urandom_range(0, 1) != 0 ? 64'd4 : 64'd0);
    else if (sel == 6) return Base + (widx << 3) + 64'($urandom_range(1, 7));
    else if (sel == 7) return Base - 64'(4 * $urandom_range(1, 16));
    else if (sel == 8) return Base + 64'(Depth * 8) + 64'(4 * $urandom_range(0, 15));
    else               return {$urandom, $urandom};
  endfunction

  initial begin
    vecs[0] = '{64'h0000_0000_8000_0000, 32'h0000_0093, 1'b0};
    vecs[1] = '{64'h0000_0000_8000_0004, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{64'h0000_0000_8000_0002, Nop,           1'b1};
    vecs[3] = '{64'h0000_0000_7FFF_FFFC, Nop,           1'b1};
    vecs[4] = '{64'h0000_0000_8000_8000, Nop,           1'b1};
    vecs[5] = '{64'h0000_0000_8000_7FFC, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{64'h0000_0000_8000_7FF8, 32'h1234_5678, 1'b0};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFC, Nop,           1'b1};
    vecs[8] = '{64'h0000_0000_0000_0000, Nop,           1'b1};

    idle();
    isram_addr = '0;
    load_idx   = '0;
    load_wdata = '0;
    load_strb  = '0;
    m_fcnt     = '0;
    m_ecnt     = '0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Preload the whole image; word 0 and the last word get known contents.
    for (int i = 0; i < int'(Depth); i++) begin
      load_we    = 1'b1;
      load_idx   = 12'(i);
      load_strb  = 8'hFF;
      load_wdata = (i == 0)                ? 64'hDEAD_BEEF_0000_0093 :
                   (i == int'(Depth) - 1)  ? 64'hCAFE_F00D_1234_5678 : {$urandom, $urandom};
      tick();
    end
    idle();

    // Table: single fetch, then all instances settle and hold that response.
    for (int i = 0; i < 9; i++) begin
      isram_e    = 1'b1;
      isram_addr = vecs[i].addr;
      tick();
      isram_e = 1'b0;
      repeat (4) tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("vec%0d_lat%0d_pc", i, lat_of(k)), rpc[k], vecs[i].addr);
        chk($sformatf("vec%0d_lat%0d_inst", i, lat_of(k)), 64'(rinst[k]), 64'(vecs[i].inst));
        chk($sformatf("vec%0d_lat%0d_err", i, lat_of(k)), 64'(rerr[k]), 64'(vecs[i].err));
      end
    end

    // Back-to-back fetches at LATENCY=1, then two faults.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    isram_e    = 1'b1;
    isram_addr = 64'h8000_0000;
    tick();
    chk("b2b_first_valid", 64'(rv[0]), 64'd1);
    chk("b2b_first_inst", 64'(rinst[0]), 64'h0000_0093);
    chk("b2b_first_pc", rpc[0], 64'h8000_0000);
    isram_addr = 64'h8000_0004;
    tick();
    chk("b2b_second_valid", 64'(rv[0]), 64'd1);
    chk("b2b_second_inst", 64'(rinst[0]), 64'hDEAD_BEEF);
    chk("b2b_second_err", 64'(rerr[0]), 64'd0);
    chk("b2b_fetch_cnt", 64'(fcnt[0]), 64'd2);
    isram_addr = 64'h8000_0002;
    tick();
    chk("misaligned_inst", 64'(rinst[0]), 64'(Nop));
    chk("misaligned_err", 64'(rerr[0]), 64'd1);
    isram_addr = 64'h7FFF_FFFC;
    tick();
    chk("below_base_inst", 64'(rinst[0]), 64'(Nop));
    chk("below_base_err", 64'(rerr[0]), 64'd1);
    chk("fault_err_cnt", 64'(ecnt[0]), 64'd2);
    idle();
    tick();

    // Flush at LATENCY=3: the two older fetches never respond.
    isram_e    = 1'b1;
    isram_addr = 64'h8000_0000;
    tick();
    isram_addr = 64'h8000_0004;
    tick();
    isram_addr = 64'h8000_0100;
    flush      = 1'b1;
    tick();
    idle();
    chk("flush_l3_c3_valid", 64'(rv[1]), 64'd0);
    tick();
    chk("flush_l3_c4_valid", 64'(rv[1]), 64'd0);
    tick();
    chk("flush_l3_c5_valid", 64'(rv[1]), 64'd1);
    chk("flush_l3_c5_pc", rpc[1], 64'h8000_0100);
    tick();

    // Same-cycle load and fetch of word 0: read-before-write.
    isram_e    = 1'b1;
    isram_addr = 64'h8000_0000;
    load_we    = 1'b1;
    load_idx   = 12'd0;
    load_strb  = 8'h0F;
    load_wdata = 64'h0000_0000_1111_1111;
    tick();
    load_we = 1'b0;
    chk("rbw_old_inst", 64'(rinst[0]), 64'h0000_0093);
    tick();
    chk("rbw_new_inst", 64'(rinst[0]), 64'h1111_1111);
    isram_addr = 64'h8000_0004;
    tick();
    chk("rbw_upper_kept", 64'(rinst[0]), 64'hDEAD_BEEF);
    idle();

    // Reset with the LATENCY=4 pipeline full.
    isram_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      isram_addr = 64'h8000_0000 + 64'(8 * i);
      tick();
    end
    rst = 1'b1;
    tick();
    idle();
    chk("rst_fetch_cnt", 64'(fcnt[2]), 64'd0);
    chk("rst_err_cnt", 64'(ecnt[2]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_l4_valid%0d", i), 64'(rv[2]), 64'd0);
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      isram_e    = ($urandom_range(0, 9) < 7);
      isram_addr = rand_addr();
      flush      = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      load_we    = ($urandom_range(0, 4) == 0);
      load_idx   = ($urandom_range(0, 1) == 0) ? 12'($urandom) : isram_addr[14:3] - Base[14:3];
      load_strb  = 8'($urandom);
      load_wdata = {$urandom, $urandom};
      tick();
    end
    idle();
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_isram_resp.md
Name: ysyx_2022040010_isram_resp

Overview:
Instruction-SRAM responder on the slave end of the fetch interface (isram_e / isram_addr) driven by the IF stage. It holds the instruction image in a 64-bit-wide word array and returns the addressed 32-bit instruction after a fixed, parameterised latency. A flush input discards in-flight fetches on a branch redirect. A byte-masked load port preloads the image, and counters expose fetch and fault statistics.

Parameters:
BASE, 64'h0000_0000_8000_0000, byte address of word 0; equals PC_MBASE.
DEPTH, 4096, number of 64-bit words (32 KiB).
LATENCY, 1, request-to-response cycles; legal range 1..4.
NOP_INST, 32'h0000_0013, instruction returned on a faulting fetch.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
isram_e  in  1  fetch request valid
isram_addr  in  64  fetch byte address
flush  in  1  redirect; kill all in-flight responses
resp_valid  out  1  response valid
resp_pc  out  64  address of the responded fetch
resp_inst  out  32  instruction
resp_err  out  1  fetch fault (misaligned or out of range)
load_we  in  1  image write enable
load_idx  in  log2(DEPTH)  word index
load_wdata  in  64  write data
load_strb  in  8  byte enables; bit i covers bits [8i+7:8i]
fetch_cnt  out  32  accepted fetches, wraps at 2^32
err_cnt  out  32  faulting fetches, wraps at 2^32

Behaviour:
- Reset, synchronous active-high: all pipeline valid bits, resp_valid, resp_pc, resp_inst, resp_err, fetch_cnt and err_cnt go to 0. Memory contents are not reset.
- No backpressure. A request is accepted in every cycle where isram_e=1 and rst=0. Throughput is 1 per cycle.
- Word index: off = isram_addr - BASE; idx = off[63:3].
- Range check: in range iff isram_addr >= BASE and idx < DEPTH. Unsigned compare, so an address below BASE is out of range.
- Alignment: misaligned iff isram_addr[1:0] != 0.
- Fault rule: err = misaligned OR out of range. On a fault, no array read is performed and the response carries NOP_INST with resp_err=1.
- Half select: isram_addr[2]=0 returns word[31:0]; isram_addr[2]=1 returns word[63:32].
- Latency: a request accepted in cycle t gives resp_valid=1 in cycle t+LATENCY, carrying that request's pc, inst and err.
  - With LATENCY=1, the array read is registered directly.
  - Each extra stage is a {valid, pc, inst, err} register.
  - The array read always happens in the first stage.
- resp_pc, resp_inst and resp_err hold their last values when resp_valid=0. Only resp_valid is guaranteed to be deasserted.
- Flush:
  - When flush=1 in cycle t, every stage valid bit is cleared at the cycle-t edge, so no older request is ever responded.
  - A request presented in cycle t itself (the redirect target) is still accepted and responds in cycle t+LATENCY.
  - Flushed requests still count in fetch_cnt, and in err_cnt if they faulted.
- Load port:
  - Writes occur at the clock edge; only bytes with load_strb[i]=1 are updated.
  - A fetch and a load to the same word in the same cycle: the fetch returns the old data (read-before-write).
  - A load with load_idx >= DEPTH is ignored.
- Counters: fetch_cnt increments on each accepted request; err_cnt increments on each accepted faulting request. Both wrap.
- Reset asserted mid-operation: in-flight responses are dropped, and no resp_valid appears in the cycle after rst.

Decomposition:
- BASE default comes from PC_MBASE in defines.v.
- Add to defines.v: ISRAM_DEPTH, ISRAM_LAT, NOP_INST constants.
- Add to defines.v: ISRAM_RESP_BUS width macro, 98 bits = {valid, err, inst[31:0], pc[63:0]}, for the downstream ID latch.
- One sub-module: ysyx_2022040010_isram_array, the DEPTH x 64 array with a byte-masked write port and a registered read port. The top level holds the range/alignment check, delay stages, flush and counters.

Test Plan:
- Preload idx0 = 64'hDEADBEEF_00000093. Fetch 0x8000_0000 then 0x8000_0004 back-to-back at LATENCY=1 -> responses 0x00000093 then 0xDEADBEEF in consecutive cycles, pcs match, err=0, fetch_cnt=2.
- Fetch 0x8000_0002 (misaligned) and 0x7FFF_FFFC (below BASE) -> both resp_inst=0x00000013, resp_err=1; err_cnt=2.
- LATENCY=3: issue a stream from 0x8000_0000, assert flush together with a fetch of 0x8000_0100 two cycles in -> the two older fetches never appear; 0x8000_0100 responds 3 cycles after its request.
- Same-cycle load (idx0, strb 8'h0F, data 64'h0000_0000_1111_1111) and fetch of 0x8000_0000 -> old 0x00000093 returned; a refetch next cycle returns 0x11111111; the upper half remains 0xDEADBEEF.
- Assert rst with the pipeline full at LATENCY=4 -> resp_valid=0 for the 4 following cycles; counters read 0.
- Fetch 0x8000_8000 (idx=4096=DEPTH) -> resp_err=1; fetch 0x8000_7FFC -> resp_err=0, high half of idx 4095.
